// File: rtl/wb_ram_ctrl_pkg.sv
// Shared definitions for the Wishbone RAM front-end.
// Holds the FSM state encoding and the log2 helper.
// The ROM front-end can reuse both.
package wb_ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RMW  = 3'd2,
        ACK  = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Ceiling log2 for parameter derivation; returns 0 for values <= 1
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_ram_ctrl_byte_merge.sv
// Per-byte-lane merge.
// A lane whose select bit is set takes its byte from new_data.
// A lane whose select bit is clear keeps its byte from old_data.
module byte_merge #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SELW  = WIDTH / 8
) (
    input  logic [WIDTH-1:0] old_data,
    input  logic [WIDTH-1:0] new_data,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] merged
);

    // Lane-wise select between the stored word and the bus write data
    always_comb begin
        merged = old_data;
        for (int unsigned i = 0; i < SELW; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_ram_ctrl.sv
// Wishbone classic slave in front of a synchronous RAM.
// The RAM has a 1-cycle registered read and no byte enables.
// Partial-word writes are done as read-modify-write.
module wb_ram_ctrl
    import wb_ram_ctrl_pkg::*;
#(
    parameter  int unsigned RAM_WORDS_SIZE  = 256,
    parameter  int unsigned RAM_WORDS_WIDTH = 32,
    parameter  int unsigned WB_ADDR_WIDTH   = 32,
    localparam int unsigned SELW            = RAM_WORDS_WIDTH / 8,
    localparam int unsigned OFS             = log2(SELW),
    localparam int unsigned AW              = log2(RAM_WORDS_SIZE)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [RAM_WORDS_WIDTH-1:0] wb_dat_i,
    input  logic [SELW-1:0]            wb_sel_i,
    output logic [RAM_WORDS_WIDTH-1:0] wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       ram_we_o,
    output logic [RAM_WORDS_WIDTH-1:0] ram_data_o,
    output logic [AW-1:0]              ram_w_addr_o,
    output logic [AW-1:0]              ram_r_addr_o,
    input  logic [RAM_WORDS_WIDTH-1:0] ram_data_i
);

    state_t                     state_q, state_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic                       we_q, we_d;
    logic [SELW-1:0]            sel_q, sel_d;
    logic [RAM_WORDS_WIDTH-1:0] wdat_q, wdat_d;
    logic [RAM_WORDS_WIDTH-1:0] rdat_q, rdat_d;

    logic                       req;
    logic                       out_of_range;
    logic [AW-1:0]              adr_idx;
    logic                       ram_we;
    logic [RAM_WORDS_WIDTH-1:0] ram_data;
    logic [RAM_WORDS_WIDTH-1:0] merged;
    logic                       unused_adr_lsb;

    // Byte-offset bits select a lane via wb_sel_i, not an address
    assign unused_adr_lsb = ^wb_adr_i[OFS-1:0];

    byte_merge #(
        .WIDTH (RAM_WORDS_WIDTH)
    ) u_merge (
        .old_data (ram_data_i),
        .new_data (wdat_q),
        .sel      (sel_q),
        .merged   (merged)
    );

    // Next-state, request latch and RAM write-port control
    always_comb begin
        req          = wb_cyc_i & wb_stb_i;
        adr_idx      = wb_adr_i[OFS +: AW];
        out_of_range = |wb_adr_i[WB_ADDR_WIDTH-1:OFS+AW];
        state_d      = state_q;
        idx_d        = idx_q;
        we_d         = we_q;
        sel_d        = sel_q;
        wdat_d       = wdat_q;
        rdat_d       = rdat_q;
        ram_we       = 1'b0;
        ram_data     = merged;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d  = adr_idx;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    if (out_of_range) begin
                        state_d = ERR;
                    end else if (!wb_we_i) begin
                        state_d = RD;
                    end else if (wb_sel_i == '1) begin
                        ram_we   = 1'b1;
                        ram_data = wb_dat_i;
                        state_d  = ACK;
                    end else if (wb_sel_i == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = RMW;
                    end
                end
            end
            RD: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    rdat_d  = ram_data_i;
                    state_d = ACK;
                end
            end
            RMW: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    ram_we  = we_q;
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    // Output decode: ack/err follow the state, addresses bypass the latch in IDLE
    always_comb begin
        wb_dat_o     = rdat_q;
        wb_ack_o     = (state_q == ACK);
        wb_err_o     = (state_q == ERR);
        ram_we_o     = ram_we & rst_n_i;
        ram_data_o   = ram_data;
        ram_r_addr_o = (state_q == IDLE) ? adr_idx : idx_q;
        ram_w_addr_o = (state_q == IDLE) ? adr_idx : idx_q;
    end

endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Bench for wb_ram_ctrl.
// Includes a behavioural RAM, a bus master and a scoreboard monitor.
module tb_wb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_i;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [7:0]  ram_w_addr, ram_r_addr;

    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    logic [31:0] ref_mem [256];
    logic [31:0] exp_dout;

    typedef struct {
        bit          is_err;
        int unsigned lat;
        logic [31:0] dat;
        int unsigned start;
    } exp_t;
    exp_t exp_q[$];

    int unsigned cyc_cnt = 0;
    int unsigned total   = 0;
    int unsigned bad     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_ram_ctrl #(
        .RAM_WORDS_SIZE  (256),
        .RAM_WORDS_WIDTH (32),
        .WB_ADDR_WIDTH   (32)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wb_cyc_i     (wb_cyc),
        .wb_stb_i     (wb_stb),
        .wb_we_i      (wb_we),
        .wb_adr_i     (wb_adr),
        .wb_dat_i     (wb_dat_i),
        .wb_sel_i     (wb_sel),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .ram_we_o     (ram_we),
        .ram_data_o   (ram_wdata),
        .ram_w_addr_o (ram_w_addr),
        .ram_r_addr_o (ram_r_addr),
        .ram_data_i   (ram_rdata)
    );

    // Synchronous RAM: registered read, write port; preload port used during reset
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_w_addr] <= ram_wdata;
        ram_rdata <= mem[ram_r_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every ack/err must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp actual=ack%0b/err%0b required=none", wb_ack_o, wb_err_o);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {30'd0, wb_err_o, wb_ack_o}, e.is_err ? 32'd2 : 32'd1);
                    check("latency", cyc_cnt - e.start, e.lat);
                    check("dat_o", wb_dat_o, e.dat);
                end
            end
        end
    end

    // One bus access; expected outcome comes from the reference memory model
    task automatic do_access(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        exp_t        e;
        int unsigned idx;
        bit          got;
        idx     = (adr >> 2) & 32'hFF;
        e.start = cyc_cnt;
        e.is_err = (adr >= 32'h400);
        if (e.is_err) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat    = 2;
            exp_dout = ref_mem[idx];
        end else begin
            e.lat = (sel == 4'hF || sel == 4'h0) ? 1 : 2;
            for (int l = 0; l < 4; l++)
                if (sel[l]) ref_mem[idx][8*l +: 8] = dat[8*l +: 8];
        end
        e.dat = exp_dout;
        exp_q.push_back(e);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
        got = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout actual=no_response required=response adr=%h", adr);
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int unsigned mism;
        rst_n = 1'b0; pl_en = 1'b1; pl_addr = '0; pl_data = '0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_i = '0; wb_sel = '0;
        exp_dout = '0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            pl_addr = 8'(i);
            pl_data = (i == 5) ? 32'hDEADBEEF : (i == 2) ? 32'hAABBCCDD : $urandom;
            ref_mem[i] = pl_data;
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_err", {31'd0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();

        // Directed cases
        do_access(0, 32'h14, 32'h0, 4'hF);
        do_access(1, 32'h8, 32'h00001234, 4'b0011);
        do_access(0, 32'h8, 32'h0, 4'hF);
        do_access(1, 32'h8, 32'h11223344, 4'hF);
        do_access(0, 32'h8, 32'h0, 4'hF);
        do_access(1, 32'h400, 32'hCAFEF00D, 4'hF);
        do_access(0, 32'h400, 32'h0, 4'hF);
        do_access(1, 32'h20, 32'h99999999, 4'h0);
        idle_cycle();
        do_access(0, 32'h20, 32'h0, 4'hF);

        // Abort a partial write while in RMW
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h1C; wb_dat_i = 32'h55667788; wb_sel = 4'b0110;
        @(posedge clk); #1;
        wb_cyc = 0; wb_stb = 0;
        @(negedge clk);
        check("abort_ram_we", {31'd0, ram_we}, 32'd0);
        check("abort_ack", {31'd0, wb_ack_o}, 32'd0);
        @(posedge clk); #1;
        do_access(0, 32'h1C, 32'h0, 4'hF);

        // Reset asserted while a read is in RD
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h14; wb_sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_dout = '0;
        check("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("midrst_err", {31'd0, wb_err_o}, 32'd0);
        check("midrst_dat", wb_dat_o, 32'd0);
        wb_we = 1; wb_adr = 32'h30; wb_dat_i = 32'h0BADF00D;
        #1;
        check("rst_gates_we", {31'd0, ram_we}, 32'd0);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();
        do_access(0, 32'h14, 32'h0, 4'hF);

        // Randomized traffic, mostly back-to-back
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = $urandom | (32'd1 << $urandom_range(10, 31));
            else
                a = {22'd0, 8'($urandom), 2'($urandom)};
            case ($urandom_range(0, 3))
                0: s = 4'hF;
                1: s = 4'h0;
                default: s = 4'($urandom);
            endcase
            d = $urandom;
            do_access(1'($urandom), a, d, s);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        repeat (4) idle_cycle();
        check("queue_empty", exp_q.size(), 32'd0);
        mism = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("mem_final_mismatches", mism, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
